// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style LCD write sequencer.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT
  } lcd_state_e;

  localparam int LCD_ON_BIT    = 31;
  localparam int LCD_RS_BIT    = 9;
  localparam int LCD_START_BIT = 8;

  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

  // Clear and home are the only instructions needing the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data == LCD_CMD_CLEAR || data == LCD_CMD_HOME);
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter shared by every timed phase of the LCD write cycle.
module lcd_timer #(
  parameter int CNT_W = 17
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)              cnt_d = load_val_i;
    else if (cnt_q != '0)    cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_driver.sv
// Turns START edges of the LSU LCD word into timed HD44780 write cycles.
// Optional one-deep request slot: define LCD_PENDING_EN.
module lcd_driver
  import lcd_pkg::*;
#(
  parameter int T_SETUP    = 2,
  parameter int T_PULSE    = 12,
  parameter int T_HOLD     = 2,
  parameter int T_EXEC     = 2000,
  parameter int T_CLR_EXEC = 76000,
  parameter int CNT_W      = 17
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_lcd_word,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic        o_lcd_on,
  output logic        o_lcd_busy,
  output logic        o_lcd_drop
);

  lcd_state_e       state_q, state_d;
  logic             start_q, on_q, drop_q, rs_q, long_q;
  logic [7:0]       data_q;
  logic             tmr_load, tmr_zero;
  logic [CNT_W-1:0] tmr_val;
  logic             accept, acc_rs;
  logic [7:0]       acc_data;
  logic             start_evt, collide, wait_done, drop_set;
  logic             pend_take, pend_rs;
  logic [7:0]       pend_data;
  logic             in_rs;
  logic [7:0]       in_data;
  logic             unused_word_bits;

  assign in_rs            = i_lcd_word[LCD_RS_BIT];
  assign in_data          = i_lcd_word[7:0];
  assign unused_word_bits = ^i_lcd_word[30:10];
  assign start_evt        = i_lcd_word[LCD_START_BIT] & ~start_q;
  assign collide          = start_evt & (state_q != ST_IDLE);
  assign wait_done        = (state_q == ST_WAIT) & tmr_zero;

`ifdef LCD_PENDING_EN
  logic       pend_valid_q, pend_rs_q, pend_store;
  logic [7:0] pend_data_q;

  // A collision in the last WAIT cycle with an empty slot is issued straight through.
  assign pend_store = collide & ~pend_valid_q & ~wait_done;
  assign pend_take  = wait_done & (pend_valid_q | collide);
  assign pend_data  = pend_valid_q ? pend_data_q : in_data;
  assign pend_rs    = pend_valid_q ? pend_rs_q   : in_rs;
  assign drop_set   = collide & pend_valid_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      pend_valid_q <= 1'b0;
      pend_rs_q    <= 1'b0;
      pend_data_q  <= '0;
    end else if (pend_store) begin
      pend_valid_q <= 1'b1;
      pend_rs_q    <= in_rs;
      pend_data_q  <= in_data;
    end else if (pend_take) begin
      pend_valid_q <= 1'b0;
    end
  end
`else
  assign pend_take = 1'b0;
  assign pend_data = '0;
  assign pend_rs   = 1'b0;
  assign drop_set  = collide;
`endif

  lcd_timer #(.CNT_W(CNT_W)) u_timer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    accept   = 1'b0;
    acc_data = in_data;
    acc_rs   = in_rs;
    case (state_q)
      ST_IDLE: if (start_evt) begin
        state_d  = ST_SETUP;
        tmr_load = 1'b1;
        tmr_val  = CNT_W'(T_SETUP - 1);
        accept   = 1'b1;
      end
      ST_SETUP: if (tmr_zero) begin
        state_d  = ST_PULSE;
        tmr_load = 1'b1;
        tmr_val  = CNT_W'(T_PULSE - 1);
      end
      ST_PULSE: if (tmr_zero) begin
        state_d  = ST_HOLD;
        tmr_load = 1'b1;
        tmr_val  = CNT_W'(T_HOLD - 1);
      end
      ST_HOLD: if (tmr_zero) begin
        state_d  = ST_WAIT;
        tmr_load = 1'b1;
        tmr_val  = long_q ? CNT_W'(T_CLR_EXEC - 1) : CNT_W'(T_EXEC - 1);
      end
      ST_WAIT: if (tmr_zero) begin
        if (pend_take) begin
          state_d  = ST_SETUP;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(T_SETUP - 1);
          accept   = 1'b1;
          acc_data = pend_data;
          acc_rs   = pend_rs;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_lcd_en   = (state_q == ST_PULSE);
    o_lcd_busy = (state_q != ST_IDLE);
  end

  // NOTE: reset clears every register here; nothing in this block is a memory array.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      start_q <= 1'b0;
      on_q    <= 1'b0;
      drop_q  <= 1'b0;
      rs_q    <= 1'b0;
      long_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      start_q <= i_lcd_word[LCD_START_BIT];
      on_q    <= i_lcd_word[LCD_ON_BIT];
      drop_q  <= drop_q | drop_set;
      if (accept) begin
        data_q <= acc_data;
        rs_q   <= acc_rs;
        long_q <= is_long_cmd(acc_rs, acc_data);
      end
    end
  end

  assign o_lcd_data = data_q;
  assign o_lcd_rs   = rs_q;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_on   = on_q;
  assign o_lcd_drop = drop_q;

endmodule

// File: tb/tb_lcd_driver.sv
// Directed self-checking bench for lcd_driver with short timing parameters.
module tb_lcd_driver;

  localparam int TS = 2, TP = 4, TH = 2, TE = 10, TC = 40;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic [31:0] i_lcd_word = '0;
  logic [7:0]  o_lcd_data;
  logic        o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on, o_lcd_busy, o_lcd_drop;

  int n_checks = 0;
  int n_fail   = 0;

  lcd_driver #(
    .T_SETUP(TS), .T_PULSE(TP), .T_HOLD(TH), .T_EXEC(TE), .T_CLR_EXEC(TC), .CNT_W(17)
  ) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_lcd_word (i_lcd_word),
    .o_lcd_data (o_lcd_data),
    .o_lcd_rs   (o_lcd_rs),
    .o_lcd_rw   (o_lcd_rw),
    .o_lcd_en   (o_lcd_en),
    .o_lcd_on   (o_lcd_on),
    .o_lcd_busy (o_lcd_busy),
    .o_lcd_drop (o_lcd_drop)
  );

  always #5 i_clk = ~i_clk;

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_reset = 1'b0;
    i_lcd_word = '0;
    repeat (2) cyc();
    i_reset = 1'b1;
    cyc();
    n_checks++;
    if ({o_lcd_data, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on, o_lcd_busy, o_lcd_drop} !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got data=%h rs=%b rw=%b en=%b on=%b busy=%b drop=%b, expected all 0",
               o_lcd_data, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on, o_lcd_busy, o_lcd_drop);
    end
  endtask

  // Issues one START edge and checks every cycle of the resulting write.
  task automatic run_write(input logic [31:0] w, input int wait_cyc, input string name);
    int   total;
    logic exp_en, exp_busy;
    total = TS + TP + TH + wait_cyc;
    i_lcd_word = w;
    cyc();
    i_lcd_word = w & ~32'h0000_0100;
    for (int c = 1; c <= total + 2; c++) begin
      exp_en   = (c >= TS + 1) && (c <= TS + TP);
      exp_busy = (c <= total);
      n_checks++;
      if (o_lcd_en !== exp_en || o_lcd_busy !== exp_busy) begin
        n_fail++;
        $display("FAIL %s en/busy c=%0d: got en=%b busy=%b, expected en=%b busy=%b",
                 name, c, o_lcd_en, o_lcd_busy, exp_en, exp_busy);
      end
      n_checks++;
      if (o_lcd_data !== w[7:0] || o_lcd_rs !== w[9] || o_lcd_on !== w[31] || o_lcd_rw !== 1'b0) begin
        n_fail++;
        $display("FAIL %s data c=%0d: got data=%h rs=%b on=%b rw=%b, expected data=%h rs=%b on=%b rw=0",
                 name, c, o_lcd_data, o_lcd_rs, o_lcd_on, o_lcd_rw, w[7:0], w[9], w[31]);
      end
      cyc();
    end
  endtask

  task automatic test_data_write();
    run_write(32'h8000_0341, TE, "data_write");
  endtask

  task automatic test_clear();
    run_write(32'h0000_0101, TC, "clear_cmd");
  endtask

  task automatic test_held_start();
    int en_cnt = 0, busy_cnt = 0;
    i_lcd_word = 32'h8000_0355;
    cyc();
    for (int c = 1; c <= 60; c++) begin
      if (c == 50) i_lcd_word = 32'h8000_0255;
      en_cnt   += int'(o_lcd_en);
      busy_cnt += int'(o_lcd_busy);
      cyc();
    end
    n_checks++;
    if (en_cnt != TP || busy_cnt != TS + TP + TH + TE) begin
      n_fail++;
      $display("FAIL held_start: got en_cycles=%0d busy_cycles=%0d, expected %0d and %0d",
               en_cnt, busy_cnt, TP, TS + TP + TH + TE);
    end
    n_checks++;
    if (o_lcd_drop !== 1'b0 || o_lcd_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL held_start_idle: got drop=%b busy=%b, expected 0 0", o_lcd_drop, o_lcd_busy);
    end
  endtask

  // Second edge lands in PULSE of the first write, third edge in its WAIT.
  task automatic test_collision();
    logic       exp_en, exp_busy, exp_drop;
    logic [7:0] exp_data;
    i_lcd_word = 32'h0000_0341;
    cyc();
    i_lcd_word = 32'h0000_0241;
    for (int c = 1; c <= 42; c++) begin
`ifdef LCD_PENDING_EN
      exp_busy = (c <= 36);
      exp_en   = (c >= 3 && c <= 6) || (c >= 21 && c <= 24);
      exp_data = (c <= 18) ? 8'h41 : 8'h42;
      exp_drop = (c >= 11);
`else
      exp_busy = (c <= 18);
      exp_en   = (c >= 3 && c <= 6);
      exp_data = 8'h41;
      exp_drop = (c >= 5);
`endif
      n_checks++;
      if (o_lcd_en !== exp_en || o_lcd_busy !== exp_busy || o_lcd_drop !== exp_drop) begin
        n_fail++;
        $display("FAIL collision c=%0d: got en=%b busy=%b drop=%b, expected en=%b busy=%b drop=%b",
                 c, o_lcd_en, o_lcd_busy, o_lcd_drop, exp_en, exp_busy, exp_drop);
      end
      n_checks++;
      if (o_lcd_data !== exp_data || o_lcd_rs !== 1'b1) begin
        n_fail++;
        $display("FAIL collision_data c=%0d: got data=%h rs=%b, expected data=%h rs=1",
                 c, o_lcd_data, o_lcd_rs, exp_data);
      end
      case (c)
        4:       i_lcd_word = 32'h0000_0342;
        5:       i_lcd_word = 32'h0000_0242;
        10:      i_lcd_word = 32'h0000_0343;
        11:      i_lcd_word = 32'h0000_0243;
        default: ;
      endcase
      cyc();
    end
  endtask

  task automatic test_reset_mid_pulse();
    i_lcd_word = 32'h8000_0341;
    cyc();
    i_lcd_word = 32'h8000_0241;
    repeat (3) cyc();
    n_checks++;
    if (o_lcd_en !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pulse_en: got en=%b, expected 1", o_lcd_en);
    end
    #2 i_reset = 1'b0;
    #1;
    n_checks++;
    if ({o_lcd_data, o_lcd_rs, o_lcd_en, o_lcd_on, o_lcd_busy, o_lcd_drop} !== 13'h0) begin
      n_fail++;
      $display("FAIL async_reset: got data=%h rs=%b en=%b on=%b busy=%b drop=%b, expected all 0",
               o_lcd_data, o_lcd_rs, o_lcd_en, o_lcd_on, o_lcd_busy, o_lcd_drop);
    end
    i_lcd_word = '0;
    cyc();
    i_reset = 1'b1;
    cyc();
    run_write(32'h8000_0344, TE, "post_reset");
    n_checks++;
    if (o_lcd_drop !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_drop: got drop=%b, expected 0", o_lcd_drop);
    end
  endtask

  initial begin
    test_reset();
    test_data_write();
    test_clear();
    test_held_start();
    test_collision();
    test_reset_mid_pulse();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
